// File: rtl/apb_gpio_ext.sv
// apb_gpio_ext: APB GPIO controller for the pad frame. Each pin has an input
// synchroniser, an optional debouncer, rise/fall/level interrupt sources
// feeding a sticky write-1-to-clear status register, and the output register
// can be updated atomically through set/clear aliases.

module apb_gpio_ext #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned PAD_NUM        = 32,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DB_WIDTH       = 8
) (
  input  logic                      sys_clk_i,
  input  logic                      sys_rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [PAD_NUM-1:0]        gpio_in_i,
  output logic [PAD_NUM-1:0]        gpio_out_o,
  output logic [PAD_NUM-1:0]        gpio_oe_o,
  output logic [PAD_NUM-1:0]        gpio_in_sync_o,
  output logic                      interrupt_o
);

  // Byte offsets of the register map; only PADDR[5:0] is decoded.
  typedef enum logic [5:0] {
    OFF_DIR      = 6'h00,
    OFF_IN       = 6'h04,
    OFF_OUT      = 6'h08,
    OFF_OUT_SET  = 6'h0C,
    OFF_OUT_CLR  = 6'h10,
    OFF_INTEN    = 6'h14,
    OFF_IRQ_RISE = 6'h18,
    OFF_IRQ_FALL = 6'h1C,
    OFF_IRQ_HIGH = 6'h20,
    OFF_STATUS   = 6'h24,
    OFF_DBEN     = 6'h28,
    OFF_DBTHR    = 6'h2C
  } reg_off_e;

  // One strobe per writable register, asserted on the commit edge only.
  typedef struct packed {
    logic dir;
    logic out;
    logic out_set;
    logic out_clr;
    logic inten;
    logic irq_rise;
    logic irq_fall;
    logic irq_high;
    logic status;
    logic dben;
    logic dbthr;
  } wr_en_t;

  // ---------------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------------
  logic [PAD_NUM-1:0]  dir_q,      dir_d;
  logic [PAD_NUM-1:0]  out_q,      out_d;
  logic [PAD_NUM-1:0]  inten_q,    inten_d;
  logic [PAD_NUM-1:0]  irq_rise_q, irq_rise_d;
  logic [PAD_NUM-1:0]  irq_fall_q, irq_fall_d;
  logic [PAD_NUM-1:0]  irq_high_q, irq_high_d;
  logic [PAD_NUM-1:0]  status_q,   status_d;
  logic [PAD_NUM-1:0]  dben_q,     dben_d;
  logic [DB_WIDTH-1:0] dbthr_q,    dbthr_d;

  // Input path state: synchroniser chain, debounced value, its delayed copy
  // and one debounce counter per pin.
  logic [PAD_NUM-1:0]  sync_q [SYNC_STAGES];
  logic [PAD_NUM-1:0]  sync_d [SYNC_STAGES];
  logic [PAD_NUM-1:0]  din_q,      din_d;
  logic [PAD_NUM-1:0]  dp_q,       dp_d;
  logic [DB_WIDTH-1:0] cnt_q [PAD_NUM];
  logic [DB_WIDTH-1:0] cnt_d [PAD_NUM];

  // ---------------------------------------------------------------------------
  // APB decode
  // ---------------------------------------------------------------------------
  logic               apb_access;
  logic               apb_write;
  logic               addr_ok;
  logic [31:0]        rdata;
  wr_en_t             we;
  logic [PAD_NUM-1:0] wdata_pad;
  logic               unused_paddr_hi;

  assign apb_access = PSEL & PENABLE;
  assign apb_write  = apb_access & PWRITE;
  assign wdata_pad  = PWDATA[PAD_NUM-1:0];

  // Address bits above the decoded window only alias the register map.
  assign unused_paddr_hi = ^PADDR[APB_ADDR_WIDTH-1:6];

  // Decode the offset into a read value, write strobes and an address-valid flag.
  // NOTE: every output of a combinational block gets a default before the case,
  // otherwise an unassigned path would infer a latch.
  always_comb begin
    addr_ok = 1'b1;
    rdata   = '0;
    we      = '0;
    case (PADDR[5:0])
      OFF_DIR: begin
        rdata  = 32'(dir_q);
        we.dir = apb_write;
      end
      OFF_IN: begin
        rdata = 32'(din_q);
      end
      OFF_OUT: begin
        rdata  = 32'(out_q);
        we.out = apb_write;
      end
      OFF_OUT_SET: begin
        we.out_set = apb_write;
      end
      OFF_OUT_CLR: begin
        we.out_clr = apb_write;
      end
      OFF_INTEN: begin
        rdata    = 32'(inten_q);
        we.inten = apb_write;
      end
      OFF_IRQ_RISE: begin
        rdata       = 32'(irq_rise_q);
        we.irq_rise = apb_write;
      end
      OFF_IRQ_FALL: begin
        rdata       = 32'(irq_fall_q);
        we.irq_fall = apb_write;
      end
      OFF_IRQ_HIGH: begin
        rdata       = 32'(irq_high_q);
        we.irq_high = apb_write;
      end
      OFF_STATUS: begin
        rdata     = 32'(status_q);
        we.status = apb_write;
      end
      OFF_DBEN: begin
        rdata   = 32'(dben_q);
        we.dben = apb_write;
      end
      OFF_DBTHR: begin
        rdata    = 32'(dbthr_q);
        we.dbthr = apb_write;
      end
      default: begin
        addr_ok = 1'b0;
      end
    endcase
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = apb_access & ~addr_ok;
  assign PRDATA  = PSEL ? rdata : '0;

  // ---------------------------------------------------------------------------
  // Event detection on the debounced value
  // ---------------------------------------------------------------------------
  logic [PAD_NUM-1:0] ev_rise;
  logic [PAD_NUM-1:0] ev_fall;
  logic [PAD_NUM-1:0] ev_high;
  logic [PAD_NUM-1:0] w1c_mask;

  assign ev_rise  =  din_q & ~dp_q & irq_rise_q;
  assign ev_fall  = ~din_q &  dp_q & irq_fall_q;
  assign ev_high  =  din_q & irq_high_q;
  assign w1c_mask = we.status ? wdata_pad : '0;

  // Next state of the software-visible registers; new events win over a
  // simultaneous W1C of the same bit.
  always_comb begin
    dir_d      = we.dir      ? wdata_pad : dir_q;
    inten_d    = we.inten    ? wdata_pad : inten_q;
    irq_rise_d = we.irq_rise ? wdata_pad : irq_rise_q;
    irq_fall_d = we.irq_fall ? wdata_pad : irq_fall_q;
    irq_high_d = we.irq_high ? wdata_pad : irq_high_q;
    dben_d     = we.dben     ? wdata_pad : dben_q;
    dbthr_d    = we.dbthr    ? PWDATA[DB_WIDTH-1:0] : dbthr_q;
    status_d   = (status_q & ~w1c_mask) | ev_rise | ev_fall | ev_high;

    out_d = out_q;
    if (we.out)     out_d = wdata_pad;
    if (we.out_set) out_d = out_q | wdata_pad;
    if (we.out_clr) out_d = out_q & ~wdata_pad;
  end

  // Register file flops.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      dir_q      <= '0;
      out_q      <= '0;
      inten_q    <= '0;
      irq_rise_q <= '0;
      irq_fall_q <= '0;
      irq_high_q <= '0;
      status_q   <= '0;
      dben_q     <= '0;
      dbthr_q    <= '0;
    end else begin
      dir_q      <= dir_d;
      out_q      <= out_d;
      inten_q    <= inten_d;
      irq_rise_q <= irq_rise_d;
      irq_fall_q <= irq_fall_d;
      irq_high_q <= irq_high_d;
      status_q   <= status_d;
      dben_q     <= dben_d;
      dbthr_q    <= dbthr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Input path: synchroniser and debouncer
  // ---------------------------------------------------------------------------
  logic [PAD_NUM-1:0] sync_s;
  logic               db_clear;
  logic               thr_zero;

  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign db_clear = we.dben | we.dbthr;
  assign thr_zero = (dbthr_q == '0);

  // Shift the raw pad value through the synchroniser chain.
  always_comb begin
    sync_d[0] = gpio_in_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Per-pin debounce: d follows s only after s has differed for T+1 cycles;
  // a threshold or enable write restarts every count.
  always_comb begin
    din_d = din_q;
    dp_d  = din_q;
    for (int p = 0; p < PAD_NUM; p++) begin
      cnt_d[p] = '0;
      if (!dben_q[p] || thr_zero) begin
        din_d[p] = sync_s[p];
      end else if (db_clear) begin
        din_d[p] = din_q[p];
      end else if (sync_s[p] != din_q[p]) begin
        if (cnt_q[p] == dbthr_q) begin
          din_d[p] = sync_s[p];
        end else begin
          cnt_d[p] = cnt_q[p] + DB_WIDTH'(1);
        end
      end
    end
  end

  // Input path flops.
  // NOTE: the counter array is plain flops, not a RAM, and is reset so that a
  // reset in the middle of a debounce window discards the partial count.
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      din_q <= '0;
      dp_q  <= '0;
      for (int p = 0; p < PAD_NUM; p++) begin
        cnt_q[p] <= '0;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      din_q <= din_d;
      dp_q  <= dp_d;
      for (int p = 0; p < PAD_NUM; p++) begin
        cnt_q[p] <= cnt_d[p];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign gpio_out_o     = out_q;
  assign gpio_oe_o      = dir_q;
  assign gpio_in_sync_o = sync_s;
  assign interrupt_o    = |(status_q & inten_q);

endmodule

// File: tb/tb_apb_gpio_ext.sv
// tb_apb_gpio_ext: directed and randomised bench for apb_gpio_ext. A cycle
// reference model built from the register-map rules predicts every read and
// the pad/interrupt outputs; reads are queued to a monitor that compares them.

module tb_apb_gpio_ext;

  localparam int unsigned SYNC = 2;

  logic        clk;
  logic        rst_n;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite, psel, penable;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [31:0] gpio_in, gpio_out, gpio_oe, gpio_sync;
  logic        irq;

  logic [31:0] n_prdata;
  logic        n_pready, n_pslverr, n_irq;
  logic [7:0]  n_out, n_oe, n_sync;

  apb_gpio_ext #(.APB_ADDR_WIDTH(12), .PAD_NUM(32), .SYNC_STAGES(SYNC), .DB_WIDTH(8)) dut (
    .sys_clk_i(clk), .sys_rst_ni(rst_n),
    .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite), .PSEL(psel), .PENABLE(penable),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .gpio_in_i(gpio_in), .gpio_out_o(gpio_out), .gpio_oe_o(gpio_oe),
    .gpio_in_sync_o(gpio_sync), .interrupt_o(irq)
  );

  apb_gpio_ext #(.APB_ADDR_WIDTH(12), .PAD_NUM(8), .SYNC_STAGES(SYNC), .DB_WIDTH(8)) dut_narrow (
    .sys_clk_i(clk), .sys_rst_ni(rst_n),
    .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite), .PSEL(psel), .PENABLE(penable),
    .PRDATA(n_prdata), .PREADY(n_pready), .PSLVERR(n_pslverr),
    .gpio_in_i(gpio_in[7:0]), .gpio_out_o(n_out), .gpio_oe_o(n_oe),
    .gpio_in_sync_o(n_sync), .interrupt_o(n_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (32 pads)
  // ---------------------------------------------------------------------------
  bit [31:0]   m_dir, m_out, m_inten, m_rise, m_fall, m_high, m_status, m_dben;
  bit [31:0]   m_d, m_dp;
  int unsigned m_thr;
  int          m_run [32];     // consecutive cycles the synchronised pin differed from d
  bit [31:0]   m_pipe [$];     // last SYNC raw samples, oldest first

  function automatic bit m_err(input logic [11:0] a);
    return (a[1:0] != 2'b00) || (a[5:0] > 6'h2C);
  endfunction

  function automatic bit [31:0] m_rdata(input logic [11:0] a);
    if (m_err(a)) return 32'h0;
    case (a[5:0])
      6'h00:   return m_dir;
      6'h04:   return m_d;
      6'h08:   return m_out;
      6'h14:   return m_inten;
      6'h18:   return m_rise;
      6'h1C:   return m_fall;
      6'h20:   return m_high;
      6'h24:   return m_status;
      6'h28:   return m_dben;
      6'h2C:   return 32'(m_thr);
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_dir = 0; m_out = 0; m_inten = 0; m_rise = 0; m_fall = 0; m_high = 0;
    m_status = 0; m_dben = 0; m_d = 0; m_dp = 0; m_thr = 0;
    for (int i = 0; i < 32; i++) m_run[i] = 0;
    m_pipe = {};
    for (int i = 0; i < SYNC; i++) m_pipe.push_back(32'h0);
  endtask

  task automatic m_step();
    bit [31:0] s, nd, ev, wd;
    bit        wr, restart;
    bit [5:0]  off;
    s       = m_pipe[0];
    wr      = psel && penable && pwrite && !m_err(paddr);
    off     = paddr[5:0];
    wd      = pwdata;
    restart = wr && (off == 6'h28 || off == 6'h2C);
    ev = (m_d & ~m_dp & m_rise) | (~m_d & m_dp & m_fall) | (m_d & m_high);
    nd = m_d;
    for (int i = 0; i < 32; i++) begin
      if (!m_dben[i] || m_thr == 0) begin
        nd[i] = s[i];
        m_run[i] = 0;
      end else if (restart) begin
        m_run[i] = 0;
      end else if (s[i] != m_d[i]) begin
        m_run[i]++;
        if (m_run[i] > int'(m_thr)) begin
          nd[i] = s[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    if (wr && off == 6'h24) m_status = m_status & ~wd;
    m_status = m_status | ev;
    m_dp = m_d;
    m_d  = nd;
    if (wr) begin
      case (off)
        6'h00: m_dir   = wd;
        6'h08: m_out   = wd;
        6'h0C: m_out   = m_out | wd;
        6'h10: m_out   = m_out & ~wd;
        6'h14: m_inten = wd;
        6'h18: m_rise  = wd;
        6'h1C: m_fall  = wd;
        6'h20: m_high  = wd;
        6'h28: m_dben  = wd;
        6'h2C: m_thr   = int'(wd[7:0]);
        default: ;
      endcase
    end
    m_pipe.push_back(gpio_in);
    void'(m_pipe.pop_front());
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and monitor
  // ---------------------------------------------------------------------------
  typedef struct {
    bit        wr;
    bit [11:0] addr;
    bit [31:0] data;
    bit        err;
  } sb_item_t;

  sb_item_t sb_q [$];

  initial begin
    sb_item_t e;
    forever begin
      @(negedge clk);
      #1;
      check("pins_out", gpio_out, m_out);
      check("pins_oe", gpio_oe, m_dir);
      check("pins_sync", gpio_sync, m_pipe[0]);
      check("interrupt", irq, 32'(|(m_status & m_inten)));
      if (psel && penable) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL scoreboard: access at 0x%03h with nothing expected", paddr);
        end else begin
          e = sb_q.pop_front();
          check("pready", pready, 32'h1);
          check($sformatf("pslverr_%03h", e.addr), pslverr, 32'(e.err));
          if (!e.wr) check($sformatf("read_%03h", e.addr), prdata, e.data);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // APB driver
  // ---------------------------------------------------------------------------
  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    sb_item_t it;
    @(negedge clk);
    paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    it.wr = 1'b1; it.addr = a; it.data = 32'h0; it.err = m_err(a);
    sb_q.push_back(it);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] rd, output logic [31:0] nrd);
    sb_item_t it;
    @(negedge clk);
    paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    it.wr = 1'b0; it.addr = a; it.data = m_rdata(a); it.err = m_err(a);
    sb_q.push_back(it);
    #1;
    rd  = prdata;
    nrd = n_prdata;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  function automatic logic [11:0] rand_addr();
    logic [11:0] a;
    a = 12'($urandom_range(0, 15) * 4);
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] rd, nrd, wd;
    logic [11:0] a;
    int unsigned sel;

    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    gpio_in = 32'hFFFF_FFFF;
    rst_n = 1'b0;

    // Reset values with all pads high.
    repeat (3) @(negedge clk);
    check("rst_irq", irq, 32'h0);
    check("rst_out", gpio_out, 32'h0);
    check("rst_oe", gpio_oe, 32'h0);
    check("rst_prdata", prdata, 32'h0);
    check("rst_pslverr", pslverr, 32'h0);
    check("rst_sync", gpio_sync, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int r = 0; r < 12; r++) apb_read(12'(r * 4), rd, nrd);
    apb_read(12'h004, rd, nrd);
    check("rst_in", rd, 32'hFFFF_FFFF);
    apb_read(12'h024, rd, nrd);
    check("rst_status", rd, 32'h0);
    check("rst_irq_after", irq, 32'h0);

    // Output set/clear precedence and direction.
    gpio_in = 32'h0;
    repeat (4) @(negedge clk);
    apb_write(12'h008, 32'h0000_00F0);
    apb_write(12'h00C, 32'h0000_0001);
    apb_write(12'h010, 32'h0000_0010);
    check("out_pins", gpio_out, 32'h0000_00E1);
    apb_read(12'h008, rd, nrd);
    check("out_reg", rd, 32'h0000_00E1);
    apb_read(12'h00C, rd, nrd);
    check("out_set_reads0", rd, 32'h0);
    apb_write(12'h000, 32'h0000_00FF);
    check("oe_pins", gpio_oe, 32'h0000_00FF);

    // Rise interrupt latency: high after the third edge, cleared by W1C.
    apb_write(12'h018, 32'h4);
    apb_write(12'h014, 32'h4);
    gpio_in[2] = 1'b1;
    repeat (3) @(negedge clk);
    check("rise_edge2", irq, 32'h0);
    @(negedge clk);
    check("rise_edge3", irq, 32'h1);
    apb_read(12'h024, rd, nrd);
    check("rise_status", rd, 32'h4);
    apb_write(12'h024, 32'h4);
    check("rise_w1c_irq", irq, 32'h0);

    // Debounce with T = 4 on pin 0: 4-cycle glitch dropped, 5-cycle pulse kept.
    apb_write(12'h018, 32'h1);
    apb_write(12'h014, 32'h1);
    apb_write(12'h028, 32'h1);
    apb_write(12'h02C, 32'h4);
    gpio_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    gpio_in[0] = 1'b0;
    repeat (8) @(negedge clk);
    apb_read(12'h004, rd, nrd);
    check("db_short_in", rd, 32'h4);
    apb_read(12'h024, rd, nrd);
    check("db_short_status", rd, 32'h0);
    gpio_in[0] = 1'b1;
    repeat (5) @(negedge clk);
    gpio_in[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("db_long_edge6", irq, 32'h0);
    @(negedge clk);
    check("db_long_edge7", irq, 32'h1);
    apb_read(12'h024, rd, nrd);
    check("db_long_status", rd, 32'h1);
    apb_write(12'h024, 32'hFFFF_FFFF);

    // Level source re-pends while the pin stays high.
    apb_write(12'h020, 32'h8);
    gpio_in[3] = 1'b1;
    repeat (4) @(negedge clk);
    apb_write(12'h024, 32'h8);
    apb_read(12'h024, rd, nrd);
    check("lvl_repend", rd, 32'h8);
    gpio_in[3] = 1'b0;
    repeat (5) @(negedge clk);
    apb_write(12'h024, 32'hFFFF_FFFF);
    apb_read(12'h024, rd, nrd);
    check("lvl_clear", rd, 32'h0);

    // Bad offsets are flagged and leave the register file untouched.
    apb_write(12'h030, 32'hFFFF_FFFF);
    apb_write(12'h002, 32'hFFFF_FFFF);
    apb_write(12'h03C, 32'hFFFF_FFFF);
    apb_read(12'h030, rd, nrd);
    check("bad_read", rd, 32'h0);
    apb_read(12'h000, rd, nrd);
    check("bad_dir_kept", rd, 32'h0000_00FF);
    apb_read(12'h02C, rd, nrd);
    check("bad_thr_kept", rd, 32'h4);

    // Narrow instance keeps only its 8 pads.
    apb_write(12'h000, 32'h0000_FFFF);
    check("narrow_oe", 32'(n_oe), 32'h0000_00FF);
    apb_read(12'h000, rd, nrd);
    check("narrow_dir", nrd, 32'h0000_00FF);
    check("wide_dir", rd, 32'h0000_FFFF);
    check("narrow_sync", 32'(n_sync), 32'(gpio_in[7:0]));

    // Randomised traffic against the model, with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (i == 200) begin
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end else if (sel < 3) begin
        gpio_in = gpio_in ^ ($urandom & $urandom);
        @(negedge clk);
      end else if (sel < 6) begin
        a  = rand_addr();
        wd = $urandom;
        if (a[5:0] == 6'h2C) wd = wd & 32'h7;
        apb_write(a, wd);
      end else if (sel < 8) begin
        apb_read(rand_addr(), rd, nrd);
      end else begin
        repeat ($urandom_range(1, 6)) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
